mux_rr_arbiter: RTL and testbench

- Upstream control stage for the 6-bit, 4-input channel multiplexer.
- Arbitrates between four requesting channels using round-robin with a burst limit.
- Drives the multiplexer's 2-bit select and a one-hot grant, and presents a valid/ready handshake to the consumer downstream of the multiplexer.
- Pops the granted channel through a per-channel ack pulse.

---
 rtl/mux_rr_arbiter_pkg.sv | 22 ++
 rtl/mux_rr_arbiter_rr_pick4.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 110 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the 4-input channel-mux arbiter: channel count,
// select width, arbiter state encoding and channel index names.
package mux_rr_arbiter_pkg;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [CH_W-1:0] CH_A = 2'd0;
    localparam logic [CH_W-1:0] CH_B = 2'd1;
    localparam logic [CH_W-1:0] CH_C = 2'd2;
    localparam logic [CH_W-1:0] CH_D = 2'd3;

    function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
        return N_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: returns the first set request bit found
// searching upward from ptr+1, wrapping modulo 4.
module rr_pick4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            found,
    output logic [CH_W-1:0] idx
);

    logic [CH_W-1:0] cand;

    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 1; k <= N_CH; k++) begin
            cand = ptr + CH_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with a per-grant burst limit driving the select of a
// 4-input channel mux, plus the downstream valid/ready and per-channel pops.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter  int BURST_LEN = 4,
    localparam int CNT_W     = $clog2(BURST_LEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            out_ready,
    output logic [CH_W-1:0] sel,
    output logic [N_CH-1:0] grant,
    output logic            out_valid,
    output logic [N_CH-1:0] ack
);

    state_e           state_q, state_d;
    logic [CH_W-1:0]  sel_q, sel_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CH_W-1:0]  last_ptr_q, last_ptr_d;

    logic             granted;
    logic             xfer;
    logic             burst_end;
    logic             owner_drop;
    logic             release_w;
    logic [N_CH-1:0]  pick_req;
    logic [CH_W-1:0]  pick_ptr;
    logic             pick_found;
    logic [CH_W-1:0]  pick_idx;

    assign granted    = (state_q == GRANT);
    assign out_valid  = granted & req[sel_q];
    assign xfer       = out_valid & out_ready;
    assign ack        = grant_q & {N_CH{xfer}};
    assign burst_end  = xfer && (beat_cnt_q == CNT_W'(BURST_LEN - 1));
    assign owner_drop = granted && !req[sel_q];
    assign release_w  = burst_end | owner_drop;

    // On release the owner drops to lowest priority; a dropped owner is also
    // masked out so it cannot be re-picked on stale state.
    assign pick_ptr = granted ? sel_q : last_ptr_q;
    assign pick_req = owner_drop ? (req & ~ch_onehot(sel_q)) : req;

    rr_pick4 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        last_ptr_d = last_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    sel_d      = pick_idx;
                    grant_d    = ch_onehot(pick_idx);
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_w) begin
                    last_ptr_d = sel_q;
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        grant_d = ch_onehot(pick_idx);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= CH_A;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            last_ptr_q <= CH_D;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: stimulus pushes the expected owner of each
// transfer into a queue, a negedge monitor pops and compares on every transfer.
module tb_mux_rr_arbiter;
    import mux_rr_arbiter_pkg::*;

    localparam int BURST_LEN = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] req;
    logic            out_ready;
    logic [CH_W-1:0] sel;
    logic [N_CH-1:0] grant;
    logic            out_valid;
    logic [N_CH-1:0] ack;

    int checks = 0;
    int errors = 0;

    logic [CH_W-1:0] exp_q[$];
    logic [CH_W-1:0] mon_exp;
    logic [N_CH-1:0] mon_ack;

    mux_rr_arbiter #(.BURST_LEN(BURST_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CH_W-1:0] ch, input int n);
        repeat (n) exp_q.push_back(ch);
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_outputs(input string tag, input logic [N_CH-1:0] g,
                                 input logic [CH_W-1:0] s, input logic v,
                                 input logic [N_CH-1:0] a);
        check({tag, "_grant"}, grant, g);
        check({tag, "_sel"}, sel, s);
        check({tag, "_valid"}, out_valid, v);
        check({tag, "_ack"}, ack, a);
    endtask

    task automatic do_reset(input string tag);
        req       = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_outputs({tag, "_rst"}, 4'b0000, CH_A, 1'b0, 4'b0000);
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every transfer must match the next queued owner.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_xfer: sel=%0d ack=%b, expected no transfer", sel, ack);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_ack = 4'b0001 << mon_exp;
                    check("xfer_sel", sel, mon_exp);
                    check("xfer_ack", ack, mon_ack);
                end
            end else begin
                check("no_xfer_ack", ack, 4'b0000);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset("init");

        // Two requesters, both ways round the rotation with no idle gap.
        req       = 4'b0101;
        out_ready = 1'b1;
        push(CH_A, 4);
        push(CH_C, 4);
        push(CH_A, 4);
        tick();
        check("rr_first_grant", grant, 4'b0001);
        check("rr_first_sel", sel, CH_A);
        for (int t = 2; t <= 13; t++) begin
            tick();
            if (t == 5) begin
                check("rr_rot_grant", grant, 4'b0100);
                check("rr_rot_sel", sel, CH_C);
            end
            if (t == 9) begin
                check("rr_back_grant", grant, 4'b0001);
                check("rr_back_sel", sel, CH_A);
            end
        end
        // Nothing left to serve: IDLE with the select held on channel c.
        req = 4'b0000;
        tick();
        check_outputs("idle", 4'b0000, CH_C, 1'b0, 4'b0000);
        check_drained("rr_drain");

        // Single requester: back-to-back re-grants across burst boundaries.
        do_reset("single");
        req       = 4'b1000;
        out_ready = 1'b1;
        push(CH_D, 10);
        tick();
        check("single_grant", grant, 4'b1000);
        for (int t = 2; t <= 11; t++) begin
            check("single_sel", sel, CH_D);
            tick();
        end
        check("single_grant_end", grant, 4'b1000);
        req = 4'b0000;
        tick();
        check_drained("single_drain");

        // Owner withdraws after two beats; channel c takes over next edge.
        do_reset("drop");
        req       = 4'b0110;
        out_ready = 1'b1;
        push(CH_B, 2);
        push(CH_C, 2);
        tick();
        check("drop_first_grant", grant, 4'b0010);
        tick();
        tick();
        req = 4'b0100;
        tick();
        check("drop_new_grant", grant, 4'b0100);
        check("drop_new_sel", sel, CH_C);
        tick();
        tick();
        req = 4'b0000;
        check_drained("drop_drain");

        // Stall mid-burst: everything frozen, the beat count resumes afterwards.
        do_reset("stall");
        req       = 4'b0011;
        out_ready = 1'b1;
        push(CH_A, 4);
        tick();
        check("stall_first_grant", grant, 4'b0001);
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_outputs("stall_hold", 4'b0001, CH_A, 1'b1, 4'b0000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("stall_rot_grant", grant, 4'b0010);
        check("stall_rot_sel", sel, CH_B);
        req = 4'b0000;
        check_drained("stall_drain");

        // Asynchronous reset between edges in the middle of a burst.
        do_reset("async");
        req       = 4'b1100;
        out_ready = 1'b1;
        push(CH_C, 2);
        tick();
        check("async_first_grant", grant, 4'b0100);
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 4'b1111;
        #1;
        check_outputs("async_mid", 4'b0000, CH_A, 1'b0, 4'b0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("async_regrant", grant, 4'b0001);
        check("async_resel", sel, CH_A);
        req       = 4'b0000;
        out_ready = 1'b0;
        tick();
        check_drained("async_drain");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
